systolic_test_control: RTL and testbench

//  Sequencer for an N x M output-stationary systolic MAC array (K-deep inner product).

---
 rtl/sa_ctrl_pkg.sv | 22 ++
 rtl/systolic_test_control_if.sv | 13 +
 rtl/sa_skew_window.sv | 22 ++
 rtl/systolic_test_control.sv | 76 +++++++
 tb/tb_systolic_test_control.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/sa_ctrl_pkg.sv
// Shared types and sizing helpers for the systolic array test controller.
package sa_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FEED     = 2'd1,
    WAIT_FIN = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Cycle (counted from the first FEED cycle) at which the last product has settled.
  function automatic int unsigned load_cycle(input int unsigned n, input int unsigned m,
                                             input int unsigned k);
    return k + n + m - 2;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n, input int unsigned m,
                                        input int unsigned k);
    return $clog2(load_cycle(n, m, k) + 1);
  endfunction

endpackage

// File: rtl/systolic_test_control_if.sv
// Control bundle between the sequencer and the array-edge operand muxes / C output stage.
interface systolic_test_control_if #(
  parameter int unsigned N = 3,
  parameter int unsigned M = 3
);
  logic         finished;
  logic [N-1:0] A_start_en;
  logic [M-1:0] B_start_en;
  logic         load;

  modport master (input finished, output A_start_en, output B_start_en, output load);
  modport slave  (output finished, input A_start_en, input B_start_en, input load);
endinterface

// File: rtl/sa_skew_window.sv
// Staggered K-wide operand windows: lane i is open while cnt is in [i*OFFSET_STEP, i*OFFSET_STEP+K-1].
module sa_skew_window #(
  parameter int unsigned LANES       = 3,
  parameter int unsigned K           = 3,
  parameter int unsigned OFFSET_STEP = 1,
  parameter int unsigned CNT_W       = 3
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             active,
  output logic [LANES-1:0] en_c
);

  logic [31:0] cnt_ext;
  assign cnt_ext = 32'(cnt);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int unsigned LO = i * OFFSET_STEP;
    // Unsigned wrap turns cnt < LO into a huge offset, so one compare covers both bounds.
    assign en_c[i] = active && ((cnt_ext - 32'(LO)) < 32'(K));
  end

endmodule

// File: rtl/systolic_test_control.sv
// Run sequencer for an N x M output-stationary systolic MAC array: skewed operand windows,
// load pulse, then wait for downstream. Define SA_CTRL_AUTORESTART_EN to restart after finished.
module systolic_test_control
  import sa_ctrl_pkg::*;
#(
  parameter int unsigned N = 3,
  parameter int unsigned M = 3,
  parameter int unsigned K = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  systolic_test_control_if.master   ctrl
);

  localparam int unsigned T  = load_cycle(N, M, K);
  localparam int unsigned CW = cnt_w(N, M, K);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          feed;
  logic [N-1:0]  a_en_c;
  logic [M-1:0]  b_en_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= FEED;
          cnt   <= '0;
        end
        FEED: begin
          if (cnt == CW'(T)) begin
            state <= WAIT_FIN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_FIN: begin
          if (ctrl.finished) begin
`ifdef SA_CTRL_AUTORESTART_EN
            state <= IDLE;
`else
            state <= DONE;
`endif
          end
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state/cnt only, so they change exactly on clock edges.
  assign feed = (state == FEED);

  sa_skew_window #(
    .LANES(N), .K(K), .OFFSET_STEP(1), .CNT_W(CW)
  ) u_a_win (
    .cnt(cnt), .active(feed), .en_c(a_en_c)
  );

  sa_skew_window #(
    .LANES(M), .K(K), .OFFSET_STEP(1), .CNT_W(CW)
  ) u_b_win (
    .cnt(cnt), .active(feed), .en_c(b_en_c)
  );

  assign ctrl.A_start_en = a_en_c;
  assign ctrl.B_start_en = b_en_c;
  assign ctrl.load       = feed && (cnt == CW'(T));

endmodule

// File: tb/tb_systolic_test_control.sv
// Directed bench for systolic_test_control: 3x3x3 instance plus a 2x4x5 non-square instance.
module tb_systolic_test_control;

  typedef struct {
    logic       fin;
    logic [3:0] a;
    logic [3:0] b;
    logic       ld;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  always #5 clk = ~clk;

  systolic_test_control_if #(.N(3), .M(3)) bus1 ();
  systolic_test_control_if #(.N(2), .M(4)) bus2 ();

  systolic_test_control #(.N(3), .M(3), .K(3)) u_dut (
    .clk(clk), .rst(rst), .ctrl(bus1.master)
  );

  systolic_test_control #(.N(2), .M(4), .K(5)) u_dut2 (
    .clk(clk), .rst(rst2), .ctrl(bus2.master)
  );

  int   total = 0;
  int   bad   = 0;
  vec_t tab1[9];
  vec_t tab2[11];
  vec_t zero_v;

  function automatic vec_t mk(input logic fin, input logic [3:0] a, input logic [3:0] b,
                              input logic ld);
    vec_t v;
    v.fin = fin;
    v.a   = a;
    v.b   = b;
    v.ld  = ld;
    return v;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input vec_t v);
    check({tag, "_a"}, 4'(bus1.A_start_en), v.a);
    check({tag, "_b"}, 4'(bus1.B_start_en), v.b);
    check({tag, "_ld"}, 4'(bus1.load), 4'(v.ld));
  endtask

  task automatic check2(input string tag, input vec_t v);
    check({tag, "_a"}, 4'(bus2.A_start_en), v.a);
    check({tag, "_b"}, 4'(bus2.B_start_en), v.b);
    check({tag, "_ld"}, 4'(bus2.load), 4'(v.ld));
  endtask

  initial begin
    rst           = 1'b1;
    rst2          = 1'b1;
    bus1.finished = 1'b0;
    bus2.finished = 1'b0;
    zero_v        = mk(1'b0, 4'b0000, 4'b0000, 1'b0);

    // 3x3x3: cnt 0..7 in FEED, then first WAIT_FIN cycle
    tab1[0] = mk(1'b0, 4'b0001, 4'b0001, 1'b0);
    tab1[1] = mk(1'b0, 4'b0011, 4'b0011, 1'b0);
    tab1[2] = mk(1'b0, 4'b0111, 4'b0111, 1'b0);
    tab1[3] = mk(1'b0, 4'b0110, 4'b0110, 1'b0);
    tab1[4] = mk(1'b0, 4'b0100, 4'b0100, 1'b0);
    tab1[5] = mk(1'b0, 4'b0000, 4'b0000, 1'b0);
    tab1[6] = mk(1'b0, 4'b0000, 4'b0000, 1'b0);
    tab1[7] = mk(1'b0, 4'b0000, 4'b0000, 1'b1);
    tab1[8] = mk(1'b0, 4'b0000, 4'b0000, 1'b0);

    // 2x4x5: T=9; A lane i open cnt i..i+4, B lane j open cnt j..j+4
    tab2[0]  = mk(1'b0, 4'b0001, 4'b0001, 1'b0);
    tab2[1]  = mk(1'b0, 4'b0011, 4'b0011, 1'b0);
    tab2[2]  = mk(1'b0, 4'b0011, 4'b0111, 1'b0);
    tab2[3]  = mk(1'b0, 4'b0011, 4'b1111, 1'b0);
    tab2[4]  = mk(1'b0, 4'b0011, 4'b1111, 1'b0);
    tab2[5]  = mk(1'b0, 4'b0010, 4'b1110, 1'b0);
    tab2[6]  = mk(1'b0, 4'b0000, 4'b1100, 1'b0);
    tab2[7]  = mk(1'b0, 4'b0000, 4'b1000, 1'b0);
    tab2[8]  = mk(1'b0, 4'b0000, 4'b0000, 1'b0);
    tab2[9]  = mk(1'b0, 4'b0000, 4'b0000, 1'b1);
    tab2[10] = mk(1'b0, 4'b0000, 4'b0000, 1'b0);

    // Reset held three cycles
    for (int c = 0; c < 3; c++) begin
      step();
      check1($sformatf("rst_c%0d", c), zero_v);
    end
    rst = 1'b0;
    check1("idle_after_rst", zero_v);

    // Basic skew run
    for (int r = 0; r < 9; r++) begin
      bus1.finished = tab1[r].fin;
      step();
      check1($sformatf("run1_r%0d", r), tab1[r]);
    end

    // Hold in WAIT_FIN without finished
    bus1.finished = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      check1($sformatf("waitfin_c%0d", c), zero_v);
    end
    bus1.finished = 1'b1;
    step();
    check1("fin_edge", zero_v);
    bus1.finished = 1'b0;
    step();
`ifdef SA_CTRL_AUTORESTART_EN
    check1("autorestart", tab1[0]);
`else
    check1("done_c0", zero_v);
    for (int c = 1; c < 10; c++) begin
      bus1.finished = c[0];
      step();
      check1($sformatf("done_c%0d", c), zero_v);
    end
`endif

    // finished held high through IDLE and FEED has no effect
    bus1.finished = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check1("idle2", zero_v);
    bus1.finished = 1'b1;
    for (int r = 0; r < 9; r++) begin
      step();
      check1($sformatf("run2_fin_r%0d", r), tab1[r]);
    end
    bus1.finished = 1'b0;

    // Mid-run reset at cnt=3
    rst = 1'b1;
    step();
    rst = 1'b0;
    check1("idle3", zero_v);
    for (int r = 0; r < 4; r++) begin
      step();
      check1($sformatf("run3_pre_r%0d", r), tab1[r]);
    end
    rst = 1'b1;
    step();
    check1("midrun_rst", zero_v);
    rst = 1'b0;
    for (int r = 0; r < 9; r++) begin
      step();
      check1($sformatf("run3_post_r%0d", r), tab1[r]);
    end

    // Non-square instance, held in reset until now
    check2("idle_nsq", zero_v);
    rst2 = 1'b0;
    for (int r = 0; r < 11; r++) begin
      step();
      check2($sformatf("nsq_r%0d", r), tab2[r]);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      check2($sformatf("nsq_wait_c%0d", c), zero_v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
